// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits (MSB- or LSB-first), optional
// even-parity bit (enabled by SERIAL_RX_PARITY_EN), stop bit; one-word holding register.
module serial_frame_receiver #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              serial_in,
  input  logic              dir,
  input  logic              out_ready,
  output logic [DATA_W-1:0] parallel_out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
`ifdef SERIAL_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic [1:0]        dbg_state_o
);

  // Output handshake: a word is transferred on any rising edge where out_valid=1 and
  // out_ready=1; parallel_out holds steady while out_valid=1 and out_ready=0.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              dir_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              word_done_d;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_bad_q;
  logic              parity_err_q;
`endif

  // dir_q=0: bits enter at bit 0 and walk up, so the first bit lands in DATA_W-1.
  // dir_q=1: bits enter at the top and walk down, so the first bit lands in bit 0.
  always_comb begin
    if (dir_q) begin
      shift_d = (shift_q >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
    end else begin
      shift_d = (shift_q << 1) | DATA_W'(serial_in);
    end
  end

  always_comb begin
    word_done_d = sample_en && (state_q == STOP) && serial_in;
`ifdef SERIAL_RX_PARITY_EN
    word_done_d = word_done_d && !par_bad_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dir_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // A completed word wins over a pending clear so back-to-back transfers keep valid high.
      if (word_done_d) begin
        if (!valid_q || out_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      if (sample_en) begin
        case (state_q)
          IDLE: begin
            if (!serial_in) begin
              state_q <= DATA;
              dir_q   <= dir;
              cnt_q   <= '0;
              shift_q <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end
          end
          DATA: begin
            shift_q <= shift_d;
            if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q <= (^shift_q) ^ serial_in;
            state_q   <= STOP;
`else
            state_q <= IDLE;
`endif
          end
          STOP: begin
            frame_err_q <= !serial_in;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= par_bad_q;
`endif
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign parallel_out = data_q;
  assign out_valid    = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state_o  = state_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed frames plus randomized frames, checked
// against a frame-level reference model and an expected-word queue.
module tb_serial_frame_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_en = 1'b0;
  logic         serial_in = 1'b1;
  logic         dir = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef SERIAL_RX_PARITY_EN
  logic         parity_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: holding register, pulses and frame-in-progress flag.
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_frame = '0;
  logic         m_valid = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;
  logic         m_par_bad = 1'b0;
  int           ready_mode = 0;
  logic [W-1:0] exp_q[$];

  serial_frame_receiver #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .serial_in    (serial_in),
    .dir          (dir),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .dbg_state_o  (dbg_state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // kind: 0 none, 1 start, 2 data, 3 parity, 4 stop (only meaningful when se=1)
  task automatic step(input logic se, input logic sin, input int kind);
    logic done;
    sample_en = se;
    serial_in = sin;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("consume_unexpected", 32'(1), 32'(0));
      else chk("consume_word", 32'(parallel_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    done   = 1'b0;
    if (se) begin
      case (kind)
        1: m_busy = 1'b1;
        3: m_par_bad = (^m_frame) ^ sin;
        4: begin
          m_busy = 1'b0;
          m_ferr = !sin;
          m_perr = m_par_bad;
          done   = sin && !m_par_bad;
        end
        default: ;
      endcase
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_word  = m_frame;
        m_valid = 1'b1;
        exp_q.push_back(m_frame);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("parallel_out", 32'(parallel_out), 32'(m_word));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef SERIAL_RX_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) begin
      dir = 1'($urandom_range(0, 1));
      step(1'b0, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  // raw[W-1] goes on the line first; the delivered word depends on dir.
  task automatic send_frame(input logic [W-1:0] raw, input logic d, input logic stop_bit,
                            input int gmax, input logic par_flip);
    m_frame   = d ? rev(raw) : raw;
    m_par_bad = 1'b0;
    gap(gmax);
    dir = d;
    step(1'b1, 1'b0, 1);
    for (int i = W - 1; i >= 0; i--) begin
      gap(gmax);
      step(1'b1, raw[i], 2);
    end
`ifdef SERIAL_RX_PARITY_EN
    gap(gmax);
    step(1'b1, (^m_frame) ^ par_flip, 3);
`else
    if (par_flip) m_par_bad = 1'b0;
`endif
    gap(gmax);
    step(1'b1, stop_bit, 4);
  endtask

  task automatic model_reset();
    m_word = '0; m_valid = 1'b0; m_busy = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_par_bad = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] raw;
    logic         d;

    // Reset values while rst is held low
    repeat (2) @(negedge clk);
    chk("rst_parallel_out", 32'(parallel_out), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;

    // Idle line with strobes must not start a frame
    ready_mode = 1;
    repeat (3) step(1'b1, 1'b1, 0);

    // LSB-first 1,0,1,1 -> 1101
    ready_mode = 0;
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
    chk("lsb_first_word", 32'(parallel_out), 32'(4'b1101));
    chk("lsb_first_valid", 32'(out_valid), 32'(1));
    ready_mode = 1;
    step(1'b1, 1'b1, 0);
    chk("consume_clears_valid", 32'(out_valid), 32'(0));

    // MSB-first, same bits -> 1011
    ready_mode = 0;
    send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);
    chk("msb_first_word", 32'(parallel_out), 32'(4'b1011));
    ready_mode = 1;
    step(1'b1, 1'b1, 0);

    // Bad stop bit
    send_frame(4'b0110, 1'b0, 1'b0, 0, 1'b0);
    chk("bad_stop_frame_err", 32'(frame_err), 32'(1));
    chk("bad_stop_no_valid", 32'(out_valid), 32'(0));
    chk("bad_stop_idle", 32'(busy), 32'(0));
    step(1'b1, 1'b1, 0);
    chk("frame_err_one_cycle", 32'(frame_err), 32'(0));

    // Overrun: A then 5 with no consumer
    ready_mode = 0;
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0);
    chk("overrun_pulse", 32'(overrun), 32'(1));
    chk("overrun_keeps_word", 32'(parallel_out), 32'(4'hA));
    step(1'b1, 1'b1, 0);
    chk("overrun_one_cycle", 32'(overrun), 32'(0));
    chk("stable_while_stalled", 32'(parallel_out), 32'(4'hA));
    ready_mode = 1;
    step(1'b1, 1'b1, 0);
    chk("valid_clears_after_ready", 32'(out_valid), 32'(0));

    // Reset after the second data bit, then frame 3
    dir = 1'b0;
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b0, 2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_parallel_out", 32'(parallel_out), 32'(0));
    @(negedge clk);
    sample_en = 1'b1;
    serial_in = 1'b1;
    rst = 1'b1;
    repeat (2) step(1'b1, 1'b1, 0);
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0);
    chk("after_rst_word", 32'(parallel_out), 32'(4'h3));
    step(1'b1, 1'b1, 0);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(4'h7, 1'b0, 1'b1, 0, 1'b1);
    chk("parity_bad_err", 32'(parity_err), 32'(1));
    chk("parity_bad_no_valid", 32'(out_valid), 32'(0));
    send_frame(4'h7, 1'b0, 1'b1, 0, 1'b0);
    chk("parity_ok_word", 32'(parallel_out), 32'(4'h7));
    step(1'b1, 1'b1, 0);
`endif

    // Randomized frames with strobe gaps, dir churn and random consumer
    repeat (40) begin
      ready_mode = $urandom_range(0, 2);
      raw = W'($urandom_range(0, (1 << W) - 1));
      d = 1'($urandom_range(0, 1));
      send_frame(raw, d, ($urandom_range(0, 9) != 0), 2, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b1, 0);
    end

    ready_mode = 1;
    repeat (3) step(1'b1, 1'b1, 0);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
